pc_redirect_ctrl: RTL
=====================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter PC_ADDR, default 32'h8000_0000, meaning the reset value of redirect_pc.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the width of every PC/target bus.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 br_valid  in  1  taken-branch redirect request, from the branch unit.
REQ-006 br_target  in  ADDR_WIDTH  branch target.
REQ-007 jmp_valid  in  1  JAL/JALR redirect request.
REQ-008 jmp_target  in  ADDR_WIDTH  jump target.
REQ-009 trap_valid  in  1  trap/exception redirect request.
REQ-010 trap_target  in  ADDR_WIDTH  trap vector.
REQ-011 if_busy  in  1  IF stage has an outstanding bus transaction and cannot accept a new PC.
REQ-012 redirect_valid  out  1  one-cycle strobe: PC SHALL load redirect_pc.
REQ-013 redirect_pc  out  ADDR_WIDTH  redirect address.
REQ-014 flush_if_id  out  1  kill the IF/ID register contents.
REQ-015 flush_id_exe  out  1  kill the ID/EXE register contents.
REQ-016 stall_pc  out  1  hold the PC register.
REQ-017 busy  out  1  controller not in IDLE.
REQ-018 last_src  out  2  source of the most recently latched request: 0 none, 1 jmp, 2 br, 3 trap.
REQ-019 redirect_cnt  out  16  count of issued redirects.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT, ISSUE; all outputs SHALL be registered.
REQ-021 Priority SHALL be trap > br > jmp; only the winner is latched, and losers in the same cycle are dropped.
REQ-022 Latched target SHALL have bits [1:0] forced to 0.
REQ-023 IDLE with any request: latch target and source; next state ISSUE if if_busy=0, else WAIT.
REQ-024 IDLE with no request: stay in IDLE; redirect_valid, flush_if_id, flush_id_exe and stall_pc all 0.
REQ-025 WAIT: stall_pc=1, flush_if_id=1 every cycle; if if_busy is sampled 0, go to ISSUE.
REQ-026 WAIT with trap_valid=1: replace the pending target and set last_src=3; the if_busy rule applies the same cycle.
REQ-027 WAIT with br_valid or jmp_valid (no trap): ignore it (wrong-path request).
REQ-028 ISSUE lasts exactly one cycle with redirect_valid=1, flush_if_id=1, stall_pc=0, and redirect_pc holding the pending target.
REQ-029 ISSUE with trap_valid=1: latch the trap and go to WAIT (if_busy=1) or ISSUE again (if_busy=0); otherwise go to IDLE.
REQ-030 ISSUE with br_valid or jmp_valid (no trap): ignore it.
REQ-031 flush_id_exe SHALL be a one-cycle pulse in the cycle after any latch, including trap preemption.
REQ-032 Latency SHALL be 1 cycle from a request to flush_id_exe, and 1 cycle to redirect_valid when if_busy=0.
REQ-033 busy SHALL be 1 in WAIT and ISSUE.
REQ-034 redirect_pc SHALL hold its last value outside ISSUE.
REQ-035 redirect_cnt SHALL increment by 1 per ISSUE cycle and saturate at 16'hFFFF; there is no wrap.

Reset
REQ-036 Reset SHALL force state IDLE, redirect_pc=PC_ADDR, last_src=0, redirect_cnt=0, and all 1-bit outputs 0.
REQ-037 Reset mid-WAIT or mid-ISSUE SHALL discard the pending request; no redirect_valid SHALL follow reset release.

Structure
REQ-038 A shared package pc_redirect_pkg SHALL hold the FSM state enum, the source enum (SRC_NONE, SRC_JMP, SRC_BR, SRC_TRAP) and the default PC_ADDR constant.
REQ-039 Priority selection SHALL be the combinational sub-module redirect_prio_sel (inputs: three valid/target pairs; outputs: winner valid, target, source).

Verification
REQ-040 br_valid=1, br_target=32'h8000_0103, if_busy=0 -> next cycle flush_id_exe=1, redirect_valid=1, redirect_pc=32'h8000_0100, last_src=2, redirect_cnt=1.
REQ-041 jmp_valid and trap_valid together (trap_target=32'h8000_1000), if_busy=1 for 3 cycles -> WAIT with stall_pc=1 for 3 cycles, then one ISSUE with redirect_pc=32'h8000_1000, last_src=3.
REQ-042 In WAIT, br_valid=1 (ignored), then trap_valid=1 -> pending target replaced by the trap target, a second flush_id_exe pulse, and one redirect only.
REQ-043 Reset asserted during WAIT -> all outputs at reset values, redirect_pc=32'h8000_0000, and no redirect_valid after release.
REQ-044 Preload redirect_cnt=16'hFFFE, then 3 redirects -> redirect_cnt reads 16'hFFFF.
REQ-045 Back-to-back br_valid in IDLE then ISSUE, if_busy=0 -> exactly one redirect; the second request is ignored and the FSM returns to IDLE.

Source files
------------

// File: rtl/pc_redirect_pkg.sv
// rtl/pc_redirect_pkg.sv - shared types and constants for the PC redirect controller
package pc_redirect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_TRAP = 2'd3
    } src_e;

    localparam logic [31:0] PC_ADDR_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/redirect_prio_sel.sv
// rtl/redirect_prio_sel.sv - fixed-priority (trap > br > jmp) redirect request selector
module redirect_prio_sel
    import pc_redirect_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  trap_valid_i,
    input  logic [ADDR_WIDTH-1:0] trap_target_i,
    input  logic                  br_valid_i,
    input  logic [ADDR_WIDTH-1:0] br_target_i,
    input  logic                  jmp_valid_i,
    input  logic [ADDR_WIDTH-1:0] jmp_target_i,
    output logic                  win_valid_o,
    output logic [ADDR_WIDTH-1:0] win_target_o,
    output src_e                  win_src_o
);

    logic [ADDR_WIDTH-1:0] raw_target;

    // Pick the single winner; the target is word-aligned since fetch is 4-byte granular.
    always_comb begin
        win_valid_o = 1'b1;
        win_src_o   = SRC_NONE;
        raw_target  = '0;
        if (trap_valid_i) begin
            win_src_o  = SRC_TRAP;
            raw_target = trap_target_i;
        end else if (br_valid_i) begin
            win_src_o  = SRC_BR;
            raw_target = br_target_i;
        end else if (jmp_valid_i) begin
            win_src_o  = SRC_JMP;
            raw_target = jmp_target_i;
        end else begin
            win_valid_o = 1'b0;
        end
        win_target_o = {raw_target[ADDR_WIDTH-1:2], 2'b00};
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - redirect FSM: latches the winning request, stalls, issues and flushes
module pc_redirect_ctrl
    import pc_redirect_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(PC_ADDR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  br_valid,
    input  logic [ADDR_WIDTH-1:0] br_target,
    input  logic                  jmp_valid,
    input  logic [ADDR_WIDTH-1:0] jmp_target,
    input  logic                  trap_valid,
    input  logic [ADDR_WIDTH-1:0] trap_target,
    input  logic                  if_busy,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  flush_if_id,
    output logic                  flush_id_exe,
    output logic                  stall_pc,
    output logic                  busy,
    output logic [1:0]            last_src,
    output logic [15:0]           redirect_cnt
);

    state_e                state_q;
    src_e                  last_src_q;
    logic [ADDR_WIDTH-1:0] pend_q;
    logic [ADDR_WIDTH-1:0] redirect_pc_q;
    logic                  redirect_valid_q;
    logic                  flush_if_id_q;
    logic                  flush_id_exe_q;
    logic                  stall_pc_q;
    logic                  busy_q;
    logic [15:0]           redirect_cnt_q;
    logic [15:0]           redirect_cnt_d;

    logic                  sel_valid;
    logic [ADDR_WIDTH-1:0] sel_target;
    src_e                  sel_src;
    logic                  latch;
    logic                  active;
    logic                  issue_next;
    logic [ADDR_WIDTH-1:0] pend_next;

    redirect_prio_sel #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_prio_sel (
        .trap_valid_i  (trap_valid),
        .trap_target_i (trap_target),
        .br_valid_i    (br_valid),
        .br_target_i   (br_target),
        .jmp_valid_i   (jmp_valid),
        .jmp_target_i  (jmp_target),
        .win_valid_o   (sel_valid),
        .win_target_o  (sel_target),
        .win_src_o     (sel_src)
    );

    // Once a redirect is pending, only a trap may replace it; br/jmp are wrong-path then.
    always_comb begin
        latch          = (state_q == ST_IDLE) ? sel_valid
                                              : (sel_valid && (sel_src == SRC_TRAP));
        pend_next      = latch ? sel_target : pend_q;
        active         = latch || (state_q == ST_WAIT);
        issue_next     = active && !if_busy;
        redirect_cnt_d = redirect_cnt_q;
        if (issue_next && (redirect_cnt_q != 16'hFFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
        end
    end

    // State and registered outputs advance together so outputs reflect the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            last_src_q       <= SRC_NONE;
            pend_q           <= PC_ADDR;
            redirect_pc_q    <= PC_ADDR;
            redirect_valid_q <= 1'b0;
            flush_if_id_q    <= 1'b0;
            flush_id_exe_q   <= 1'b0;
            stall_pc_q       <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            flush_id_exe_q <= latch;
            pend_q         <= pend_next;
            if (latch) begin
                last_src_q <= sel_src;
            end
            if (!active) begin
                state_q          <= ST_IDLE;
                redirect_valid_q <= 1'b0;
                flush_if_id_q    <= 1'b0;
                stall_pc_q       <= 1'b0;
                busy_q           <= 1'b0;
            end else if (if_busy) begin
                state_q          <= ST_WAIT;
                redirect_valid_q <= 1'b0;
                flush_if_id_q    <= 1'b1;
                stall_pc_q       <= 1'b1;
                busy_q           <= 1'b1;
            end else begin
                state_q          <= ST_ISSUE;
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= pend_next;
                flush_if_id_q    <= 1'b1;
                stall_pc_q       <= 1'b0;
                busy_q           <= 1'b1;
            end
        end
    end

    // Issued-redirect counter, saturating rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_cnt_q <= 16'd0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if_id    = flush_if_id_q;
    assign flush_id_exe   = flush_id_exe_q;
    assign stall_pc       = stall_pc_q;
    assign busy           = busy_q;
    assign last_src       = last_src_q;
    assign redirect_cnt   = redirect_cnt_q;

endmodule
